sdrc_req_split: RTL

SDRC_REQ_SPLIT -- requirements
Module: sdrc_req_split

---
 rtl/sdrc_req_split_pkg.sv | 33 +++
 rtl/sdrc_req_split_if.sv | 54 +++++
 rtl/sdrc_req_fifo.sv | 51 +++++
 rtl/sdrc_req_split.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sdrc_req_split_pkg.sv
// Shared definitions for the SDRAM request splitter: engine states,
// sdr_width codes, default parameter values and the width-scaling helper.
package sdrc_req_split_pkg;

  localparam int APP_AW_DEF     = 26;
  localparam int APP_RW_DEF     = 9;
  localparam int REQ_ID_W_DEF   = 4;
  localparam int BA_W_DEF       = 2;
  localparam int ROW_W_DEF      = 13;
  localparam int LEN_W_DEF      = 12;
  localparam int FIFO_DEPTH_DEF = 4;

  // Column address port width on the bank side.
  localparam int CADDR_W = 13;

  // sdr_width codes; bit 1 set means x8 regardless of bit 0.
  localparam logic [1:0] SDR_X32 = 2'b00;
  localparam logic [1:0] SDR_X16 = 2'b01;
  localparam logic [1:0] SDR_X8  = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // Left-shift applied to address and length: x32 -> 0, x16 -> 1, x8 -> 2.
  function automatic logic [1:0] width_shift(input logic [1:0] sdr_width);
    if (sdr_width[1])            return 2'd2;
    else if (sdr_width == SDR_X16) return 2'd1;
    else                         return 2'd0;
  endfunction

endpackage

// File: rtl/sdrc_req_split_if.sv
// Application request and bank-side chunk handshake bundle.
// The splitter is the slave; the modport master is the peer driving both sides.
interface sdrc_req_split_if
  import sdrc_req_split_pkg::*;
#(
  parameter int APP_AW   = APP_AW_DEF,
  parameter int APP_RW   = APP_RW_DEF,
  parameter int REQ_ID_W = REQ_ID_W_DEF,
  parameter int BA_W     = BA_W_DEF,
  parameter int ROW_W    = ROW_W_DEF,
  parameter int LEN_W    = LEN_W_DEF
);

  // Application side
  logic                req;
  logic [REQ_ID_W-1:0] req_id;
  logic [APP_AW-1:0]   req_addr;
  logic [APP_RW-1:0]   req_len;
  logic                req_wr_n;
  logic                req_wrap;
  logic                req_ack;

  // Bank side
  logic                r2x_idle;
  logic                r2b_req;
  logic                r2b_start;
  logic                r2b_last;
  logic                r2b_wrap;
  logic                r2b_write;
  logic [REQ_ID_W-1:0] r2b_req_id;
  logic [BA_W-1:0]     r2b_ba;
  logic [ROW_W-1:0]    r2b_raddr;
  logic [CADDR_W-1:0]  r2b_caddr;
  logic [LEN_W-1:0]    r2b_len;
  logic                b2r_ack;
  logic                b2r_arb_ok;

  modport slave (
    input  req, req_id, req_addr, req_len, req_wr_n, req_wrap,
    input  b2r_ack, b2r_arb_ok,
    output req_ack, r2x_idle,
    output r2b_req, r2b_start, r2b_last, r2b_wrap, r2b_write,
    output r2b_req_id, r2b_ba, r2b_raddr, r2b_caddr, r2b_len
  );

  modport master (
    output req, req_id, req_addr, req_len, req_wr_n, req_wrap,
    output b2r_ack, b2r_arb_ok,
    input  req_ack, r2x_idle,
    input  r2b_req, r2b_start, r2b_last, r2b_wrap, r2b_write,
    input  r2b_req_id, r2b_ba, r2b_raddr, r2b_caddr, r2b_len
  );

endinterface

// File: rtl/sdrc_req_fifo.sv
// Request queue: power-of-two depth, synchronous push/pop, full/empty flags.
// Pushes while full and pops while empty are ignored.
module sdrc_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q;
  logic [PW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[PW-1:0]];

  // Read/write pointer update.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  // Storage write.
  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sdrc_req_split.sv
// Splits application requests into page-bounded chunks for the bank logic.
// Requests are width-scaled on entry, queued, then issued one chunk at a time;
// a chunk never crosses a column page unless the request is a wrap burst.
module sdrc_req_split
  import sdrc_req_split_pkg::*;
#(
  parameter int APP_AW     = APP_AW_DEF,
  parameter int APP_RW     = APP_RW_DEF,
  parameter int REQ_ID_W   = REQ_ID_W_DEF,
  parameter int BA_W       = BA_W_DEF,
  parameter int ROW_W      = ROW_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           cfg_colbits,
  input  logic [1:0]           sdr_width,
  sdrc_req_split_if.slave      bus
);

  localparam int IAW = APP_AW + 2;                       // scaled address width
  localparam int EW  = REQ_ID_W + 2 + IAW + LEN_W;        // queue entry width
  localparam int CW  = ((LEN_W > CADDR_W) ? LEN_W : CADDR_W) + 1;

  // ---------------- request queue ----------------
  logic [1:0]          shamt;
  logic [IAW-1:0]      push_addr;
  logic [LEN_W-1:0]    push_len;
  logic [EW-1:0]       wdata;
  logic [EW-1:0]       rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;

  logic [REQ_ID_W-1:0] head_id;
  logic                head_write;
  logic                head_wrap;
  logic [IAW-1:0]      head_addr;
  logic [LEN_W-1:0]    head_len;

  assign shamt     = width_shift(sdr_width);
  assign push_addr = {2'b00, bus.req_addr} << shamt;
  assign push_len  = LEN_W'(bus.req_len) << shamt;
  assign wdata     = {bus.req_id, ~bus.req_wr_n, bus.req_wrap, push_addr, push_len};
  assign {head_id, head_write, head_wrap, head_addr, head_len} = rdata;

  // Acceptance is combinational and blocked while the queue is full or in reset.
  assign bus.req_ack = bus.req & ~fifo_full & ~reset;

  sdrc_req_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.req_ack),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- issue engine ----------------
  state_e              state_q;
  logic [IAW-1:0]      addr_q;
  logic [LEN_W-1:0]    rem_q;
  logic                r2b_req_q, r2b_start_q, r2b_last_q, r2b_wrap_q, r2b_write_q;
  logic [REQ_ID_W-1:0] r2b_id_q;
  logic [BA_W-1:0]     r2b_ba_q;
  logic [ROW_W-1:0]    r2b_row_q;
  logic [CADDR_W-1:0]  r2b_col_q;
  logic [LEN_W-1:0]    r2b_len_q;

  logic [IAW-1:0]      addr_d;
  logic [LEN_W-1:0]    rem_d;
  logic                wrap_d;
  logic [3:0]          cbits;
  logic [CADDR_W-1:0]  page;
  logic [CADDR_W-1:0]  col_d;
  logic [CADDR_W-1:0]  room;
  logic [LEN_W-1:0]    len_d;
  logic                load_first;
  logic                load_next;

  // Pop gated by arbitration; zero-length heads are popped and dropped.
  assign pop        = (state_q == ST_IDLE) && !fifo_empty && bus.b2r_arb_ok;
  assign load_first = pop && (head_len != '0);
  assign load_next  = (state_q == ST_ISSUE) && bus.b2r_ack && !r2b_last_q;

  // Source of the next chunk: queue head when idle, advanced cursor when issuing.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    addr_d = head_addr;
    rem_d  = head_len;
    wrap_d = head_wrap;
    if (state_q == ST_ISSUE) begin
      addr_d = addr_q + IAW'(r2b_len_q);
      rem_d  = rem_q - r2b_len_q;
      wrap_d = r2b_wrap_q;
    end
  end

  // Chunk length limited by the distance to the end of the column page.
  assign cbits = 4'd8 + {2'b00, cfg_colbits};
  assign page  = CADDR_W'(1) << cbits;
  assign col_d = CADDR_W'(addr_d) & (page - CADDR_W'(1));
  assign room  = page - col_d;
  assign len_d = (wrap_d || (CW'(rem_d) <= CW'(room))) ? rem_d : LEN_W'(room);

  // Engine FSM with registered bank-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      r2b_req_q   <= 1'b0;
      r2b_start_q <= 1'b0;
      r2b_last_q  <= 1'b0;
      r2b_wrap_q  <= 1'b0;
      r2b_write_q <= 1'b0;
      r2b_id_q    <= '0;
      r2b_ba_q    <= '0;
      r2b_row_q   <= '0;
      r2b_col_q   <= '0;
      r2b_len_q   <= '0;
    end else begin
      if (load_first || load_next) begin
        addr_q      <= addr_d;
        rem_q       <= rem_d;
        r2b_req_q   <= 1'b1;
        r2b_start_q <= load_first;
        r2b_last_q  <= (len_d == rem_d);
        r2b_wrap_q  <= wrap_d;
        r2b_ba_q    <= BA_W'(addr_d >> cbits);
        r2b_row_q   <= ROW_W'(addr_d >> (cbits + BA_W));
        r2b_col_q   <= col_d;
        r2b_len_q   <= len_d;
      end
      if (load_first) begin
        r2b_id_q    <= head_id;
        r2b_write_q <= head_write;
      end
      case (state_q)
        ST_IDLE: begin
          if (load_first) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (bus.b2r_ack && r2b_last_q) begin
            state_q   <= ST_IDLE;
            r2b_req_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.r2x_idle   = ~bus.req & fifo_empty & (state_q == ST_IDLE);
  assign bus.r2b_req    = r2b_req_q;
  assign bus.r2b_start  = r2b_start_q;
  assign bus.r2b_last   = r2b_last_q;
  assign bus.r2b_wrap   = r2b_wrap_q;
  assign bus.r2b_write  = r2b_write_q;
  assign bus.r2b_req_id = r2b_id_q;
  assign bus.r2b_ba     = r2b_ba_q;
  assign bus.r2b_raddr  = r2b_row_q;
  assign bus.r2b_caddr  = r2b_col_q;
  assign bus.r2b_len    = r2b_len_q;

endmodule
